mux4to1_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 4:1 multiplexer path between four requesters.
- Drives the mux select, grant and per-requester acknowledges.
- Presents the selected requester's data downstream over a valid/ready handshake.
- Caps each tenure at MAX_BURST accepted transfers so no requester can starve the others.

---
 rtl/mux4to1_rr_arbiter_pkg.sv | 16 +
 rtl/mux4to1_rr_arbiter_rr_pick4.sv | 29 ++
 rtl/mux4to1_rr_arbiter.sv | 92 +++++++++
 tb/tb_mux4to1_rr_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mux4to1_rr_arbiter_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter: FSM encoding, sizes and a one-hot helper.
package mux4to1_rr_arbiter_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot = N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4to1_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request after 'last', wrapping modulo 4.
module rr_pick4
    import mux4to1_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    logic             found;
    logic [SEL_W-1:0] idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        // k = 4 wraps to 'last' itself, so the previous grantee is searched last.
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (req[idx] && !found) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/mux4to1_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux path; each tenure is capped at MAX_BURST transfers.
module mux4to1_rr_arbiter
    import mux4to1_rr_arbiter_pkg::*;
#(
    parameter int unsigned DW        = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*DW-1:0]   a,
    output logic [SEL_W-1:0]      sel,
    output logic [N_REQ-1:0]      grant,
    output logic [DW-1:0]         y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_REQ-1:0]      ack
);

    localparam int unsigned BW = $clog2(MAX_BURST) + 1;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [BW-1:0]    burst_q, burst_d;

    logic [SEL_W-1:0] winner;
    logic             any;
    logic             xfer;

    rr_pick4 u_pick (
        .req    (req),
        .last   (last_q),
        .winner (winner),
        .any    (any)
    );

    assign out_valid = (state_q == ST_GRANT) && req[sel_q];
    assign xfer      = out_valid && out_ready;
    assign ack       = xfer ? onehot(sel_q) : '0;
    assign y         = a[int'(sel_q) * DW +: DW];
    assign sel       = sel_q;
    assign grant     = grant_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        grant_d = grant_q;
        burst_d = burst_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any) begin
                    state_d = ST_GRANT;
                    sel_d   = winner;
                    grant_d = onehot(winner);
                    burst_d = '0;
                end
            end
            ST_GRANT: begin
                // Requester withdrew, or its burst quota is used up: release.
                if (!req[sel_q] || (xfer && burst_q == BW'(MAX_BURST - 1))) begin
                    state_d = ST_IDLE;
                    last_d  = sel_q;
                    grant_d = '0;
                    burst_d = '0;
                end else if (xfer) begin
                    burst_d = burst_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(N_REQ - 1);
            grant_q <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
        end
    end

endmodule

// File: tb/tb_mux4to1_rr_arbiter.sv
// Directed self-checking bench for mux4to1_rr_arbiter (DW=1, MAX_BURST=4).
module tb_mux4to1_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] a;
    logic [1:0] sel;
    logic [3:0] grant;
    logic [0:0] y;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] ack;

    int n_tests = 0;
    int n_fail  = 0;

    mux4to1_rr_arbiter #(
        .DW        (1),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a         (a),
        .sel       (sel),
        .grant     (grant),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        oh = 4'b0001 << i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'b1111;
        a         = 4'b1010;
        out_ready = 1'b1;

        // Reset held 2 cycles with all requesting
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_y", 32'(y), 32'h0);
        rst = 1'b0;
        tick();
        check("first_grant", 32'(grant), 32'h1);

        // Fairness: 5 tenures of 4 acks, one idle cycle each
        for (int r = 0; r < 5; r++) begin
            for (int b = 0; b < 4; b++) begin
                check($sformatf("fair_grant_%0d_%0d", r, b), 32'(grant), 32'(oh(r % 4)));
                check($sformatf("fair_ack_%0d_%0d", r, b), 32'(ack), 32'(oh(r % 4)));
                tick();
            end
            check($sformatf("fair_idle_grant_%0d", r), 32'(grant), 32'h0);
            check($sformatf("fair_idle_valid_%0d", r), 32'(out_valid), 32'h0);
            check($sformatf("fair_idle_ack_%0d", r), 32'(ack), 32'h0);
            tick();
        end

        // Data path
        do_reset();
        req = 4'b0100;
        tick();
        check("dp_sel2", 32'(sel), 32'h2);
        check("dp_valid2", 32'(out_valid), 32'h1);
        check("dp_y2", 32'(y), 32'h0);
        req = 4'b1000;
        #1;
        check("dp_drop_valid", 32'(out_valid), 32'h0);
        check("dp_drop_ack", 32'(ack), 32'h0);
        tick();
        check("dp_idle_grant", 32'(grant), 32'h0);
        check("dp_idle_sel", 32'(sel), 32'h2);
        tick();
        check("dp_sel3", 32'(sel), 32'h3);
        check("dp_valid3", 32'(out_valid), 32'h1);
        check("dp_y3", 32'(y), 32'h1);

        // Backpressure on requester 1
        do_reset();
        out_ready = 1'b0;
        req       = 4'b0010;
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold_grant_%0d", i), 32'(grant), 32'h2);
            check($sformatf("bp_hold_ack_%0d", i), 32'(ack), 32'h0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_ack_%0d", i), 32'(ack), 32'h2);
            check($sformatf("bp_grant_%0d", i), 32'(grant), 32'h2);
            tick();
        end
        check("bp_release_grant", 32'(grant), 32'h0);
        check("bp_release_valid", 32'(out_valid), 32'h0);
        tick();
        check("bp_sole_regrant", 32'(grant), 32'h2);

        // Early release of requester 2 after two transfers
        do_reset();
        req = 4'b0100;
        tick();
        check("er_ack1", 32'(ack), 32'h4);
        tick();
        check("er_ack2", 32'(ack), 32'h4);
        tick();
        req = 4'b0001;
        #1;
        check("er_drop_valid", 32'(out_valid), 32'h0);
        check("er_drop_ack", 32'(ack), 32'h0);
        check("er_drop_grant", 32'(grant), 32'h4);
        tick();
        check("er_idle_grant", 32'(grant), 32'h0);
        tick();
        check("er_next_grant", 32'(grant), 32'h1);
        check("er_next_sel", 32'(sel), 32'h0);

        // Reset during third transfer of requester 3
        do_reset();
        req = 4'b1000;
        tick();
        check("rm_ack1", 32'(ack), 32'h8);
        tick();
        check("rm_ack2", 32'(ack), 32'h8);
        tick();
        rst = 1'b1;
        req = 4'b1111;
        #1;
        check("rm_ack3", 32'(ack), 32'h8);
        tick();
        check("rm_rst_grant", 32'(grant), 32'h0);
        check("rm_rst_valid", 32'(out_valid), 32'h0);
        check("rm_rst_ack", 32'(ack), 32'h0);
        check("rm_rst_sel", 32'(sel), 32'h0);
        check("rm_rst_y", 32'(y), 32'h0);
        rst = 1'b0;
        tick();
        check("rm_post_grant", 32'(grant), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
